part_1_bucket_pipe: RTL and testbench

//  Parametrised first-part bucket stage of the SandwichSketch pipeline. Each accepted item {key,cnt,hash}

---
 rtl/part_1_bucket_pipe.sv | 237 +++++++++++++++++++++++
 tb/tb_part_1_bucket_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/part_1_bucket_pipe.sv
`default_nettype none
// ============================================================================
// Module   : part_1_bucket_pipe
// Purpose  : SandwichSketch first-part bucket stage; per-item bucket RMW with
//            hazard forwarding, saturating merge and table clear.
// Revision : 1.0  initial release
// ============================================================================
module part_1_bucket_pipe #(
    parameter int KEY_W     = 32,
    parameter int CNT_W     = 32,
    parameter int HASH_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int HASH_BASE = 0,
    parameter int RND_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [KEY_W-1:0]  in_key,
    input  logic [CNT_W-1:0]  in_cnt,
    input  logic [HASH_W-1:0] in_hash,
    output logic              out_valid,
    output logic [KEY_W-1:0]  out_key,
    output logic [CNT_W-1:0]  out_cnt,
    output logic [HASH_W-1:0] out_hash,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              clr_done
);
    localparam int DEPTH  = 2**ADDR_W;
    localparam int WORD_W = KEY_W + CNT_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_done_q, clr_done_d;
    logic              clr_we;

    logic              s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic [KEY_W-1:0]  s1_key_q, s1_key_d, s2_key_q, s2_key_d, s3_key_q, s3_key_d;
    logic [CNT_W-1:0]  s1_cnt_q, s1_cnt_d, s2_cnt_q, s2_cnt_d, s3_cnt_q, s3_cnt_d;
    logic [HASH_W-1:0] s1_hash_q, s1_hash_d, s2_hash_q, s2_hash_d, s3_hash_q, s3_hash_d;

    logic              fwd_valid_q, fwd_valid_d;
    logic [ADDR_W-1:0] fwd_addr_q, fwd_addr_d;
    logic [WORD_W-1:0] fwd_data_q, fwd_data_d;

    logic              out_valid_q, out_valid_d;
    logic [KEY_W-1:0]  out_key_q, out_key_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [HASH_W-1:0] out_hash_q, out_hash_d;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] s2_addr, s3_addr;

    logic [WORD_W-1:0] bucket;
    logic [KEY_W-1:0]  bkt_key;
    logic [CNT_W-1:0]  bkt_cnt;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  rnd;
    logic              item_we;
    logic [WORD_W-1:0] item_wdata;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;

    assign s2_addr = s2_hash_q[HASH_BASE +: ADDR_W];
    assign s3_addr = s3_hash_q[HASH_BASE +: ADDR_W];

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            clr_addr_q <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_done_q <= clr_done_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE:  if (clr_start) state_d = ST_DRAIN;
            ST_DRAIN: begin
                clr_addr_d = '0;
                if (!(s1_valid_q || s2_valid_q || s3_valid_q)) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {ADDR_W{1'b1}}) begin
                    state_d    = ST_IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready = (state_q == ST_IDLE);
        clr_busy = (state_q != ST_IDLE);
        clr_we   = (state_q == ST_CLEAR);
    end

    // Datapath: stage shift, forwarding and bucket decision
    always_comb begin
        s1_valid_d = in_valid && in_ready;
        s1_key_d   = in_key;
        s1_cnt_d   = in_cnt;
        s1_hash_d  = in_hash;
        s2_valid_d = s1_valid_q;
        s2_key_d   = s1_key_q;
        s2_cnt_d   = s1_cnt_q;
        s2_hash_d  = s1_hash_q;
        s3_valid_d = s2_valid_q;
        s3_key_d   = s2_key_q;
        s3_cnt_d   = s2_cnt_q;
        s3_hash_d  = s2_hash_q;

        // RAM read saw memory before the previous edge's write; patch that one in.
        bucket     = (fwd_valid_q && (fwd_addr_q == s3_addr)) ? fwd_data_q : rd_data_q;
        bkt_key    = bucket[WORD_W-1:CNT_W];
        bkt_cnt    = bucket[CNT_W-1:0];
        cnt_sum    = {1'b0, bkt_cnt} + {1'b0, s3_cnt_q};
        rnd        = (s3_cnt_q >> RND_SHIFT) + bkt_cnt;

        item_we     = 1'b0;
        item_wdata  = {s3_key_q, s3_cnt_q};
        out_valid_d = 1'b0;
        out_key_d   = out_key_q;
        out_cnt_d   = out_cnt_q;
        out_hash_d  = out_hash_q;

        if (s3_valid_q) begin
            if (bucket == '0) begin
                item_we = 1'b1;
            end else if (bkt_key == s3_key_q) begin
                item_we    = 1'b1;
                item_wdata = {s3_key_q, cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0]};
            end else if (rnd <= s3_cnt_q) begin
                item_we     = 1'b1;
                out_valid_d = 1'b1;
                out_key_d   = bkt_key;
                out_cnt_d   = bkt_cnt;
                out_hash_d  = s3_hash_q;
            end else begin
                out_valid_d = 1'b1;
                out_key_d   = s3_key_q;
                out_cnt_d   = s3_cnt_q;
                out_hash_d  = s3_hash_q;
            end
        end

        fwd_valid_d = item_we;
        fwd_addr_d  = s3_addr;
        fwd_data_d  = item_wdata;

        mem_we    = item_we;
        mem_waddr = s3_addr;
        mem_wdata = item_wdata;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            s1_key_q    <= '0;
            s2_key_q    <= '0;
            s3_key_q    <= '0;
            s1_cnt_q    <= '0;
            s2_cnt_q    <= '0;
            s3_cnt_q    <= '0;
            s1_hash_q   <= '0;
            s2_hash_q   <= '0;
            s3_hash_q   <= '0;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_key_q   <= '0;
            out_cnt_q   <= '0;
            out_hash_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            s3_valid_q  <= s3_valid_d;
            s1_key_q    <= s1_key_d;
            s2_key_q    <= s2_key_d;
            s3_key_q    <= s3_key_d;
            s1_cnt_q    <= s1_cnt_d;
            s2_cnt_q    <= s2_cnt_d;
            s3_cnt_q    <= s3_cnt_d;
            s1_hash_q   <= s1_hash_d;
            s2_hash_q   <= s2_hash_d;
            s3_hash_q   <= s3_hash_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            out_valid_q <= out_valid_d;
            out_key_q   <= out_key_d;
            out_cnt_q   <= out_cnt_d;
            out_hash_q  <= out_hash_d;
        end
    end

    // Bucket RAM: contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
        rd_data_q <= mem_q[s2_addr];
    end

    assign out_valid = out_valid_q;
    assign out_key   = out_key_q;
    assign out_cnt   = out_cnt_q;
    assign out_hash  = out_hash_q;
    assign clr_done  = clr_done_q;

endmodule
`default_nettype wire

// File: tb/tb_part_1_bucket_pipe.sv
`default_nettype none
// Testbench for part_1_bucket_pipe: directed vectors with hand-computed expected values.
module tb_part_1_bucket_pipe;
    localparam int KEY_W  = 16;
    localparam int CNT_W  = 8;
    localparam int HASH_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [KEY_W-1:0]  in_key = '0;
    logic [CNT_W-1:0]  in_cnt = '0;
    logic [HASH_W-1:0] in_hash = '0;
    logic              out_valid;
    logic [KEY_W-1:0]  out_key;
    logic [CNT_W-1:0]  out_cnt;
    logic [HASH_W-1:0] out_hash;
    logic              clr_start = 1'b0;
    logic              clr_busy;
    logic              clr_done;

    always #5 clk = ~clk;

    part_1_bucket_pipe #(
        .KEY_W(KEY_W), .CNT_W(CNT_W), .HASH_W(HASH_W),
        .ADDR_W(ADDR_W), .HASH_BASE(0), .RND_SHIFT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_key(in_key), .in_cnt(in_cnt), .in_hash(in_hash),
        .out_valid(out_valid), .out_key(out_key), .out_cnt(out_cnt), .out_hash(out_hash),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    int n_chk = 0;
    int n_pass = 0;
    int n_out = 0;
    logic [KEY_W-1:0]  last_key = '0;
    logic [CNT_W-1:0]  last_cnt = '0;
    logic [HASH_W-1:0] last_hash = '0;

    always @(negedge clk) begin
        if (out_valid) begin
            n_out     <= n_out + 1;
            last_key  <= out_key;
            last_cnt  <= out_cnt;
            last_hash <= out_hash;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] c, input logic [HASH_W-1:0] h);
        in_valid = 1'b1;
        in_key   = k;
        in_cnt   = c;
        in_hash  = h;
        step(1);
        in_valid = 1'b0;
    endtask

    function automatic logic [63:0] bkt(input logic [ADDR_W-1:0] a);
        return 64'(dut.mem_q[a]);
    endfunction

    function automatic logic [63:0] word(input logic [KEY_W-1:0] k, input logic [CNT_W-1:0] c);
        return 64'({k, c});
    endfunction

    // Waits for clr_done; pulses clr_start once mid-clear, which must be ignored.
    task automatic wait_clear(output int busy_cnt, output bit rdy_seen, output bit done_seen);
        busy_cnt  = 0;
        rdy_seen  = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (clr_done) begin
                done_seen = 1'b1;
                break;
            end
            if (clr_busy) busy_cnt++;
            if (in_ready) rdy_seen = 1'b1;
            clr_start = (i == 5);
            step(1);
        end
        clr_start = 1'b0;
    endtask

    int  busy;
    bit  rdy;
    bit  done;
    int  o0;
    logic [63:0] acc;

    initial begin
        // Reset state
        step(3);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_key",   64'(out_key),   64'd0);
        chk("rst_out_cnt",   64'(out_cnt),   64'd0);
        chk("rst_out_hash",  64'(out_hash),  64'd0);
        chk("rst_clr_busy",  64'(clr_busy),  64'd0);
        chk("rst_clr_done",  64'(clr_done),  64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        rst_n = 1'b1;
        step(2);

        // Establish a known-empty table
        clr_start = 1'b1;
        step(1);
        clr_start = 1'b0;
        wait_clear(busy, rdy, done);
        chk("clr0_done",     64'(done), 64'd1);
        chk("clr0_busy_len", 64'(busy), 64'(DEPTH + 1));
        chk("clr0_ready_lo", 64'(rdy),  64'd0);
        chk("clr0_ready_hi", 64'(in_ready), 64'd1);
        step(1);
        chk("clr0_done_pulse", 64'(clr_done), 64'd0);

        // Empty insert then merge
        o0 = n_out;
        send(16'd5, 8'd3, 16'd7);
        step(4);
        chk("ins_bucket", bkt(4'd7), word(16'd5, 8'd3));
        send(16'd5, 8'd4, 16'd7);
        step(4);
        chk("merge_bucket", bkt(4'd7), word(16'd5, 8'd7));
        chk("merge_no_out", 64'(n_out - o0), 64'd0);

        // Back-to-back same address
        for (int i = 0; i < 4; i++) send(16'd9, 8'd1, 16'd3);
        step(5);
        chk("fwd_bucket", bkt(4'd3), word(16'd9, 8'd4));
        chk("fwd_no_out", 64'(n_out - o0), 64'd0);

        // Saturation
        send(16'd1, 8'd250, 16'd5);
        step(4);
        send(16'd1, 8'd10, 16'd5);
        step(4);
        chk("sat_bucket", bkt(4'd5), word(16'd1, 8'd255));
        chk("sat_no_out", 64'(n_out - o0), 64'd0);

        // Replacement accepted: rnd = 2+4 = 6 <= 8, latency 3
        send(16'd2, 8'd4, 16'd9);
        step(4);
        send(16'd3, 8'd8, 16'h0019);
        step(2);
        chk("rep_lat_early", 64'(out_valid), 64'd0);
        step(1);
        chk("rep_valid", 64'(out_valid), 64'd1);
        chk("rep_key",   64'(out_key),   64'd2);
        chk("rep_cnt",   64'(out_cnt),   64'd4);
        chk("rep_hash",  64'(out_hash),  64'h0019);
        step(1);
        chk("rep_pulse", 64'(out_valid), 64'd0);
        chk("rep_bucket", bkt(4'd9), word(16'd3, 8'd8));

        // Replacement rejected: rnd = 2+40 = 42 > 8
        send(16'd2, 8'd40, 16'd10);
        step(4);
        send(16'd3, 8'd8, 16'h002A);
        step(3);
        chk("rej_valid", 64'(out_valid), 64'd1);
        chk("rej_key",   64'(out_key),   64'd3);
        chk("rej_cnt",   64'(out_cnt),   64'd8);
        chk("rej_hash",  64'(out_hash),  64'h002A);
        step(1);
        chk("rej_bucket", bkt(4'd10), word(16'd2, 8'd40));

        // rnd wraps: (40>>2)+250 = 260 -> 4 <= 40, replace
        o0 = n_out;
        send(16'd4, 8'd250, 16'd11);
        step(4);
        send(16'd6, 8'd40, 16'd11);
        step(4);
        chk("wrap_nout", 64'(n_out - o0), 64'd1);
        chk("wrap_out",  {8'd0, last_key, last_cnt, last_hash}, {8'd0, 16'd4, 8'd250, 16'd11});
        chk("wrap_bucket", bkt(4'd11), word(16'd6, 8'd40));

        // Back-to-back insert then replacement: rnd = 25+1 = 26 <= 100
        o0 = n_out;
        send(16'd7, 8'd1, 16'd12);
        send(16'd8, 8'd100, 16'd12);
        step(4);
        chk("b2b_rep_nout", 64'(n_out - o0), 64'd1);
        chk("b2b_rep_out",  {8'd0, last_key, last_cnt, last_hash}, {8'd0, 16'd7, 8'd1, 16'd12});
        chk("b2b_rep_bucket", bkt(4'd12), word(16'd8, 8'd100));

        // Clear with 3 items in flight, each rejected against {2,40}
        o0 = n_out;
        send(16'd11, 8'd1, 16'd10);
        send(16'd12, 8'd1, 16'd10);
        clr_start = 1'b1;
        send(16'd13, 8'd1, 16'd10);
        clr_start = 1'b0;
        wait_clear(busy, rdy, done);
        chk("clr_done",     64'(done), 64'd1);
        chk("clr_busy_len", 64'(busy), 64'(DEPTH + 4));
        chk("clr_ready_lo", 64'(rdy),  64'd0);
        chk("clr_inflight_out", 64'(n_out - o0), 64'd3);
        chk("clr_last_key", 64'(last_key), 64'd13);
        acc = '0;
        for (int a = 0; a < DEPTH; a++) acc = acc | bkt(4'(a));
        chk("clr_all_zero", acc, 64'd0);
        step(2);
        chk("clr_restart_ignored", 64'(clr_busy), 64'd0);

        // Async reset mid-clear
        send(16'd7, 8'd7, 16'd15);
        step(4);
        clr_start = 1'b1;
        step(1);
        clr_start = 1'b0;
        step(6);
        chk("pre_rst_busy", 64'(clr_busy), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy",     64'(clr_busy),  64'd0);
        chk("arst_out_key",  64'(out_key),   64'd0);
        chk("arst_out_cnt",  64'(out_cnt),   64'd0);
        chk("arst_out_hash", 64'(out_hash),  64'd0);
        chk("arst_in_ready", 64'(in_ready),  64'd1);
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        chk("post_rst_busy",  64'(clr_busy), 64'd0);
        chk("partial_clear_kept", bkt(4'd15), word(16'd7, 8'd7));
        send(16'd7, 8'd1, 16'd15);
        step(4);
        chk("post_rst_merge", bkt(4'd15), word(16'd7, 8'd8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
